// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID-stage instruction, detects load-use and
// branch-operand hazards, and carries control through ID/EX, EX/MEM and MEM/WB.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_id,
    input  logic                  id_valid,
    input  logic                  equal_to,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  ex_alu_src,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd_field;

    assign opcode   = instr_id[6:0];
    assign funct3   = instr_id[14:12];
    assign rs1      = REG_ADDR_W'(instr_id[19:15]);
    assign rs2      = REG_ADDR_W'(instr_id[24:20]);
    assign rd_field = REG_ADDR_W'(instr_id[11:7]);

    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr_id[31], instr_id[29:25]};

    logic [1:0] d_alu_op;
    logic       d_ok, d_src, d_mr, d_mw, d_rw, d_m2r, d_branch, use_rs1, use_rs2;

    always_comb begin
        d_ok     = 1'b0;
        d_alu_op = 2'b00;
        d_src    = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_rw     = 1'b0;
        d_m2r    = 1'b0;
        d_branch = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    d_ok = 1'b1; d_alu_op = 2'b10; d_rw = 1'b1;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_LW: begin
                    d_ok = 1'b1; d_src = 1'b1; d_mr = 1'b1; d_rw = 1'b1; d_m2r = 1'b1;
                    use_rs1 = 1'b1;
                end
                OP_SW: begin
                    d_ok = 1'b1; d_src = 1'b1; d_mw = 1'b1;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_BEQ: begin
                    d_ok = 1'b1; d_alu_op = 2'b01; d_branch = 1'b1;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_ADDI: begin
                    d_ok = 1'b1; d_src = 1'b1; d_rw = 1'b1;
                    use_rs1 = 1'b1;
                end
                default: d_ok = 1'b0;
            endcase
        end
    end

    // Unrecognised opcodes and bubbles must not leak the default add code.
    logic [ALU_CTRL_W-1:0] d_alu_ctrl;
    always_comb begin
        d_alu_ctrl = ALU_CTRL_W'(4'b0010);
        case (d_alu_op)
            2'b01: d_alu_ctrl = ALU_CTRL_W'(4'b0110);
            2'b10: begin
                case ({instr_id[30], funct3})
                    4'b1000: d_alu_ctrl = ALU_CTRL_W'(4'b0110);
                    4'b0111: d_alu_ctrl = ALU_CTRL_W'(4'b0000);
                    4'b0110: d_alu_ctrl = ALU_CTRL_W'(4'b0001);
                    default: d_alu_ctrl = ALU_CTRL_W'(4'b0010);
                endcase
            end
            default: d_alu_ctrl = ALU_CTRL_W'(4'b0010);
        endcase
        if (!d_ok) d_alu_ctrl = '0;
    end

    logic [REG_ADDR_W-1:0] d_rd;
    assign d_rd = d_rw ? rd_field : '0;

    logic                  idex_src, idex_mr, idex_mw, idex_rw, idex_m2r;
    logic [ALU_CTRL_W-1:0] idex_alu_ctrl;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  exmem_mr, exmem_mw, exmem_rw, exmem_m2r;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  memwb_rw, memwb_m2r;
    logic [REG_ADDR_W-1:0] memwb_rd;

    logic m_idex, m_exmem, haz_a, haz_b, haz_c, stall;
    assign m_idex  = (idex_rd != '0) &&
                     ((use_rs1 && idex_rd == rs1) || (use_rs2 && idex_rd == rs2));
    assign m_exmem = (exmem_rd != '0) &&
                     ((use_rs1 && exmem_rd == rs1) || (use_rs2 && exmem_rd == rs2));
    assign haz_a   = idex_mr & m_idex;
    assign haz_b   = d_branch & idex_rw & m_idex;
    assign haz_c   = d_branch & exmem_mr & m_exmem;
    assign stall   = id_valid & (haz_a | haz_b | haz_c);

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign if_id_flush = id_valid & d_branch & equal_to & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_src      <= 1'b0;
            idex_alu_ctrl <= '0;
            idex_mr       <= 1'b0;
            idex_mw       <= 1'b0;
            idex_rw       <= 1'b0;
            idex_m2r      <= 1'b0;
            idex_rd       <= '0;
            exmem_mr      <= 1'b0;
            exmem_mw      <= 1'b0;
            exmem_rw      <= 1'b0;
            exmem_m2r     <= 1'b0;
            exmem_rd      <= '0;
            memwb_rw      <= 1'b0;
            memwb_m2r     <= 1'b0;
            memwb_rd      <= '0;
        end else begin
            // A stalled cycle inserts a bubble into ID/EX; later stages always advance.
            idex_src      <= stall ? 1'b0 : d_src;
            idex_alu_ctrl <= stall ? '0   : d_alu_ctrl;
            idex_mr       <= stall ? 1'b0 : d_mr;
            idex_mw       <= stall ? 1'b0 : d_mw;
            idex_rw       <= stall ? 1'b0 : d_rw;
            idex_m2r      <= stall ? 1'b0 : d_m2r;
            idex_rd       <= stall ? '0   : d_rd;
            exmem_mr      <= idex_mr;
            exmem_mw      <= idex_mw;
            exmem_rw      <= idex_rw;
            exmem_m2r     <= idex_m2r;
            exmem_rd      <= idex_rd;
            memwb_rw      <= exmem_rw;
            memwb_m2r     <= exmem_m2r;
            memwb_rd      <= exmem_rd;
        end
    end

    assign ex_alu_src    = idex_src;
    assign ex_alu_ctrl   = idex_alu_ctrl;
    assign mem_read      = exmem_mr;
    assign mem_write     = exmem_mw;
    assign wb_reg_write  = memwb_rw;
    assign wb_mem_to_reg = memwb_m2r;
    assign wb_rd         = memwb_rd;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)       stall_cnt_q <= stall_cnt_q + 1'b1;
            if (if_id_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
